plm_bank_scheduler: RTL and testbench

- Shares NBANKS×NPORTS PLM bank ports (kernels) between NCONSUMERS requesters.
- Decodes the bank from each request address and runs per-kernel round-robin arbitration with a valid/ready handshake.
- Drives registered commands to the PLM and routes read data back to the owning consumer at a fixed latency.
- Sits between consumer pipelines and the banked PLM.

---
 rtl/plm_sched_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/plm_bank_scheduler.sv | 99 +++++++++
 tb/tb_plm_bank_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plm_sched_pkg.sv
// Shared widths, PLM command layout and consumer-to-kernel mapping for the
// banked-PLM request scheduler.
package plm_sched_pkg;
  localparam int ADDR_W  = 4;
  localparam int VALUE_W = 8;
  localparam int N_CONS  = 8;
  localparam int N_BANKS = 4;
  localparam int N_PORTS = 2;

  localparam int NKERNELS        = N_BANKS * N_PORTS;
  localparam int BANK_BITS       = $clog2(N_BANKS);
  localparam int BANK_ADDR_WIDTH = ADDR_W - BANK_BITS;
  localparam int PLM_INPUT_WIDTH = 2 + BANK_ADDR_WIDTH + VALUE_W;
  localparam int CID_WIDTH       = $clog2(N_CONS);
  localparam int KID_WIDTH       = $clog2(NKERNELS);

  typedef struct packed {
    logic                       en;
    logic                       we;
    logic [BANK_ADDR_WIDTH-1:0] bank_addr;
    logic [VALUE_W-1:0]         wdata;
  } plm_cmd_t;

  // Bank comes from the low address bits; the port is fixed by consumer id.
  function automatic logic [KID_WIDTH-1:0] kernel_of(input logic [CID_WIDTH-1:0] consumer,
                                                     input logic [ADDR_W-1:0]    addr);
    return KID_WIDTH'((int'(addr) % N_BANKS) * N_PORTS + int'(consumer) % N_PORTS);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above pivot, cyclic.
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pivot,
  output logic [N-1:0] gnt,
  output logic [W-1:0] winner
);
  logic [W-1:0] idx;
  logic         found;

  // N is a power of two, so pivot+i wraps modulo N by truncation.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = pivot + W'(i);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end
endmodule

// File: rtl/plm_bank_scheduler.sv
// Arbitrates consumer requests onto NBANKS*NPORTS PLM kernels, registers the
// PLM commands and returns read data to the owning consumer three cycles later.
module plm_bank_scheduler
  import plm_sched_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int VALUE_WIDTH = VALUE_W,
  parameter int NCONSUMERS  = N_CONS,
  parameter int NBANKS      = N_BANKS,
  parameter int NPORTS      = N_PORTS
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NCONSUMERS-1:0]                         req_valid,
  input  logic [NCONSUMERS-1:0]                         req_we,
  input  logic [NCONSUMERS-1:0][ADDR_WIDTH-1:0]         req_addr,
  input  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]        req_wdata,
  output logic [NCONSUMERS-1:0]                         req_ready,
  output logic [NBANKS*NPORTS-1:0][PLM_INPUT_WIDTH-1:0] plm_out,
  input  logic [NBANKS*NPORTS-1:0][VALUE_WIDTH-1:0]     plm_rdata,
  output logic [NCONSUMERS-1:0]                         resp_valid,
  output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]        resp_data
);
  logic [NKERNELS-1:0][NCONSUMERS-1:0]        kreq, kgnt;
  logic [NKERNELS-1:0][CID_WIDTH-1:0]         pivot, winner;
  logic [NKERNELS-1:0]                        kany;
  plm_cmd_t [NKERNELS-1:0]                    cmd_q;
  logic [NKERNELS-1:0][1:0]                   rd_vld_pipe;
  logic [NKERNELS-1:0][1:0][CID_WIDTH-1:0]    cid_pipe;
  logic [NCONSUMERS-1:0]                      gnt_any, rsp_vld_d;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0]     rsp_data_d;

  always_comb begin
    kreq = '0;
    for (int k = 0; k < NKERNELS; k++)
      for (int c = 0; c < NCONSUMERS; c++)
        kreq[k][c] = req_valid[c] && (kernel_of(CID_WIDTH'(c), req_addr[c]) == KID_WIDTH'(k));
  end

  for (genvar k = 0; k < NKERNELS; k++) begin : g_arb
    rr_arbiter #(.N(NCONSUMERS), .W(CID_WIDTH)) u_arb (
      .req    (kreq[k]),
      .pivot  (pivot[k]),
      .gnt    (kgnt[k]),
      .winner (winner[k])
    );
    assign kany[k] = |kgnt[k];
  end

  always_comb begin
    gnt_any = '0;
    for (int k = 0; k < NKERNELS; k++) gnt_any |= kgnt[k];
  end

  // No handshake may complete while reset holds the datapath.
  assign req_ready = {NCONSUMERS{reset}} & gnt_any;
  assign plm_out   = cmd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pivot       <= '0;
      cmd_q       <= '0;
      rd_vld_pipe <= '0;
      cid_pipe    <= '0;
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        if (kany[k]) pivot[k] <= winner[k] + 1'b1;
        cmd_q[k].en        <= kany[k];
        cmd_q[k].we        <= kany[k] & req_we[winner[k]];
        cmd_q[k].bank_addr <= kany[k] ? req_addr[winner[k]][ADDR_WIDTH-1:BANK_BITS] : '0;
        cmd_q[k].wdata     <= kany[k] ? req_wdata[winner[k]] : '0;
        rd_vld_pipe[k]     <= {rd_vld_pipe[k][0], kany[k] & ~req_we[winner[k]]};
        cid_pipe[k]        <= {cid_pipe[k][0], winner[k]};
      end
    end
  end

  // A consumer owns at most one kernel per cycle, so lanes never collide.
  always_comb begin
    rsp_vld_d  = '0;
    rsp_data_d = '0;
    for (int k = 0; k < NKERNELS; k++) begin
      if (rd_vld_pipe[k][1]) begin
        rsp_vld_d[cid_pipe[k][1]]  = 1'b1;
        rsp_data_d[cid_pipe[k][1]] = plm_rdata[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= rsp_vld_d;
      resp_data  <= rsp_data_d;
    end
  end
endmodule

// File: tb/tb_plm_bank_scheduler.sv
// Bench for plm_bank_scheduler: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_plm_bank_scheduler;
  import plm_sched_pkg::*;
  localparam int NC = 8, NK = 8, AW = 4, VW = 8, NB = 4, NP = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic [NC-1:0]          req_valid, req_we, req_ready, resp_valid;
  logic [NC-1:0][AW-1:0]  req_addr;
  logic [NC-1:0][VW-1:0]  req_wdata, resp_data;
  logic [NK-1:0][PLM_INPUT_WIDTH-1:0] plm_out;
  logic [NK-1:0][VW-1:0]  plm_rdata;
  logic [VW-1:0]          mem [NB][4];
  logic [VW-1:0]          refmem [NB][4];
  int checks = 0, failures = 0;

  plm_bank_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .plm_out(plm_out), .plm_rdata(plm_rdata), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // PLM model: one-cycle read latency, reads see the pre-edge contents.
  always @(posedge clk) begin
    for (int k = 0; k < NK; k++) begin
      plm_cmd_t cmd;
      cmd = plm_out[k];
      if (cmd.en) begin
        if (cmd.we) mem[k / NP][cmd.bank_addr] <= cmd.wdata;
        else        plm_rdata[k] <= mem[k / NP][cmd.bank_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();  @(posedge clk); #1; endtask
  task automatic settle(); #1; endtask
  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask
  task automatic do_reset();
    reset = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic int kmap(int c, int a);
    return (a % NB) * NP + c % NP;
  endfunction

  typedef struct {
    logic [NC-1:0]      v;
    logic [NC-1:0]      we;
    logic [NC*AW-1:0]   addr;
    logic [NC-1:0]      exp_rdy;
  } vec_t;
  vec_t vecs[8];

  typedef struct { int due; int c; logic [VW-1:0] d; } rsp_t;
  rsp_t q[$];

  logic [NC-1:0]         pv, pwe, exp_rdy, exp_v, pend;
  logic [NC-1:0][AW-1:0] pa;
  logic [NC-1:0][VW-1:0] pd, exp_d, act_d;
  logic [NK-1:0][PLM_INPUT_WIDTH-1:0] exp_plm;
  int piv[NK], win[NK], gcyc[NC], rcyc[NC], order[4], anyresp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int b = 0; b < NB; b++) for (int a = 0; a < 4; a++) mem[b][a] = '0;
    plm_rdata = '0;
    idle();
    #2;
    chk("reset_ready", 128'(req_ready), 128'(0));
    chk("reset_plm_out", 128'(plm_out), 128'(0));
    chk("reset_resp_valid", 128'(resp_valid), 128'(0));
    chk("reset_resp_data", 128'(resp_data), 128'(0));

    // ---- table: per-cycle grants from a fresh reset (pivots evolve row to row)
    vecs[0] = '{8'h08, 8'h08, 32'h0000_6000, 8'h08};
    vecs[1] = '{8'h06, 8'h00, 32'h0000_0330, 8'h06};
    vecs[2] = '{8'hFF, 8'h00, 32'h0000_0000, 8'h03};
    vecs[3] = '{8'hFF, 8'h00, 32'h0000_0000, 8'h0C};
    vecs[4] = '{8'hF0, 8'h00, 32'h7211_0000, 8'hF0};
    vecs[5] = '{8'h00, 8'h00, 32'h0000_0000, 8'h00};
    vecs[6] = '{8'hFF, 8'hFF, 32'h0000_0000, 8'h30};
    vecs[7] = '{8'h81, 8'h00, 32'h0000_0004, 8'h81};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].v; req_we = vecs[i].we; req_addr = vecs[i].addr;
      for (int c = 0; c < NC; c++) req_wdata[c] = 8'(8'h10 + c);
      settle();
      chk($sformatf("table_ready[%0d]", i), 128'(req_ready), 128'(vecs[i].exp_rdy));
      step();
    end
    idle();

    // ---- write: consumer 3, addr 6, data A5
    do_reset();
    req_valid = 8'h08; req_we = 8'h08; req_addr[3] = 4'h6; req_wdata[3] = 8'hA5;
    settle();
    chk("wr_ready", 128'(req_ready), 128'(8'h08));
    step(); idle(); settle();
    exp_plm = '0; exp_plm[5] = 12'hDA5;
    chk("wr_plm_out", 128'(plm_out), 128'(exp_plm));
    anyresp = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid != 0) anyresp = 1;
      step();
    end
    chk("wr_no_resp", 128'(anyresp), 128'(0));

    // ---- read: consumer 0, addr 1, memory preloaded with 3C
    req_valid = 8'h01; req_we = 8'h01; req_addr[0] = 4'h1; req_wdata[0] = 8'h3C;
    step(); idle(); step();
    req_valid = 8'h01; req_addr[0] = 4'h1;
    settle();
    chk("rd_ready", 128'(req_ready), 128'(8'h01));
    step(); idle(); settle();
    chk("rd_plm_cmd", 128'(plm_out[2][11:8]), 128'(4'b1000));
    chk("rd_resp_t1", 128'(resp_valid), 128'(0));
    step();
    chk("rd_resp_t2", 128'(resp_valid), 128'(0));
    step();
    chk("rd_resp_t3", 128'(resp_valid), 128'(8'h01));
    chk("rd_data_t3", 128'(resp_data[0]), 128'(8'h3C));
    step();
    chk("rd_resp_t4", 128'(resp_valid), 128'(0));

    // ---- four readers on kernel 0: grant and response order
    do_reset();
    pend = 8'h55;
    for (int c = 0; c < NC; c++) begin gcyc[c] = -1; rcyc[c] = -1; end
    for (int r = 0; r < 10; r++) begin
      req_valid = pend; req_addr = '0; req_we = '0;
      settle();
      for (int c = 0; c < NC; c++) begin
        if (req_ready[c]) gcyc[c] = r;
        if (resp_valid[c]) rcyc[c] = r;
      end
      pend &= ~req_ready;
      step();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rr_grant_cyc_c%0d", 2 * j), 128'(gcyc[2 * j]), 128'(j));
      chk($sformatf("rr_resp_cyc_c%0d", 2 * j), 128'(rcyc[2 * j]), 128'(j + 3));
    end
    chk("rr_pivot0", 128'(dut.pivot[0]), 128'(7));

    // ---- consumer 0 re-requests every cycle against a held consumer 2
    do_reset();
    for (int r = 0; r < 4; r++) begin
      req_valid = 8'h05; req_addr = '0;
      settle();
      order[r] = req_ready[2] ? 2 : (req_ready[0] ? 0 : -1);
      step();
    end
    idle();
    chk("alt_order", 128'({8'(order[0]), 8'(order[1]), 8'(order[2]), 8'(order[3])}),
        128'(32'h00020002));

    // ---- reset during an in-flight read, then 6 vs 0 contention
    do_reset();
    req_valid = 8'h20; req_addr[5] = 4'h1;
    settle();
    chk("rst_rd_ready", 128'(req_ready), 128'(8'h20));
    step();
    reset = 1'b0; idle(); req_valid = 8'h40;
    settle();
    chk("rst_plm_out", 128'(plm_out), 128'(0));
    chk("rst_ready_gated", 128'(req_ready), 128'(0));
    step(); step();
    reset = 1'b1;
    pend = 8'h41; anyresp = 0;
    for (int c = 0; c < NC; c++) gcyc[c] = -1;
    for (int r = 0; r < 5; r++) begin
      req_valid = pend; req_we = 8'h41; req_addr = '0;
      settle();
      if (resp_valid != 0) anyresp = 1;
      for (int c = 0; c < NC; c++) if (req_ready[c]) gcyc[c] = r;
      pend &= ~req_ready;
      step();
    end
    idle();
    chk("rst_dropped_resp", 128'(anyresp), 128'(0));
    chk("rst_first_c0", 128'(gcyc[0]), 128'(0));
    chk("rst_then_c6", 128'(gcyc[6]), 128'(1));

    // ---- randomized run against the reference model
    do_reset();
    for (int b = 0; b < NB; b++) for (int a = 0; a < 4; a++) refmem[b][a] = mem[b][a];
    for (int k = 0; k < NK; k++) piv[k] = 0;
    pv = '0; pwe = '0; pa = '0; pd = '0; q.delete();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NC; c++) begin
        if (!pv[c]) begin
          if ($urandom_range(1, 0) == 1) begin
            pv[c] = 1'b1; pwe[c] = ($urandom_range(3, 0) == 0);
            pa[c] = 4'($urandom); pd[c] = 8'($urandom);
          end
        end else if ($urandom_range(7, 0) == 0) pv[c] = 1'b0;
      end
      req_valid = pv; req_we = pwe; req_addr = pa; req_wdata = pd;
      settle();
      exp_rdy = '0;
      for (int k = 0; k < NK; k++) begin
        win[k] = -1;
        for (int off = 0; off < NC; off++) begin
          int c;
          c = (piv[k] + off) % NC;
          if (win[k] < 0 && pv[c] && kmap(c, int'(pa[c])) == k) win[k] = c;
        end
        if (win[k] >= 0) exp_rdy[win[k]] = 1'b1;
      end
      chk("rand_ready", 128'(req_ready), 128'(exp_rdy));
      exp_v = '0; exp_d = '0; act_d = '0;
      foreach (q[i]) if (q[i].due == n) begin exp_v[q[i].c] = 1'b1; exp_d[q[i].c] = q[i].d; end
      for (int c = 0; c < NC; c++) if (exp_v[c]) act_d[c] = resp_data[c];
      chk("rand_resp_valid", 128'(resp_valid), 128'(exp_v));
      chk("rand_resp_data", 128'(act_d), 128'(exp_d));
      q = q.find(x) with (x.due > n);
      for (int k = 0; k < NK; k++) if (win[k] >= 0 && !pwe[win[k]])
        q.push_back('{n + 3, win[k], refmem[int'(pa[win[k]]) % NB][int'(pa[win[k]]) / NB]});
      for (int k = 0; k < NK; k++) if (win[k] >= 0) begin
        if (pwe[win[k]]) refmem[int'(pa[win[k]]) % NB][int'(pa[win[k]]) / NB] = pd[win[k]];
        pv[win[k]] = 1'b0;
        piv[k] = (win[k] + 1) % NC;
      end
      step();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
